// File: rtl/aoc5_pkg.sv
// Shared types for the range-drain slice: tuple layout, padding sentinel,
// bank address width and the drain FSM state encoding.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif

package aoc5_pkg;

   localparam int ID_WIDTH = 32;

   typedef struct packed {
      logic [ID_WIDTH-1:0] lo;
      logic [ID_WIDTH-1:0] hi;
   } tuple_pair_t;

   localparam tuple_pair_t TUPLE_SENTINEL = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_PROC_EVEN,
      S_PROC_ODD,
      S_FLUSH,
      S_DONE
   } drain_state_t;

   function automatic logic is_sentinel(input tuple_pair_t t);
      return t == TUPLE_SENTINEL;
   endfunction

endpackage

// File: rtl/aoc5_range_accum.sv
// Coalesces a sorted stream of inclusive ranges and accumulates the number of
// covered IDs; one tuple per enabled cycle, flush closes the open range.
module aoc5_range_accum
   import aoc5_pkg::*;
#(
   parameter int TOTAL_WIDTH = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   tuple_valid,
   input  tuple_pair_t            tuple_in,
   input  logic                   flush,
   output logic [TOTAL_WIDTH-1:0] total
);

   tuple_pair_t            cur_q;
   logic                   have_cur_q;
   logic [TOTAL_WIDTH-1:0] total_q;
   logic [TOTAL_WIDTH-1:0] span;

   // Inclusive span of the open range, wrapping modulo 2^TOTAL_WIDTH.
   assign span  = TOTAL_WIDTH'(cur_q.hi) - TOTAL_WIDTH'(cur_q.lo) + TOTAL_WIDTH'(1);
   assign total = total_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_q      <= '0;
         have_cur_q <= 1'b0;
         total_q    <= '0;
      end else if (en) begin
         if (clear) begin
            have_cur_q <= 1'b0;
            total_q    <= '0;
         end else if (flush) begin
            if (have_cur_q) total_q <= total_q + span;
            have_cur_q <= 1'b0;
         end else if (tuple_valid && !is_sentinel(tuple_in)) begin
            if (!have_cur_q) begin
               cur_q      <= tuple_in;
               have_cur_q <= 1'b1;
            end else if (tuple_in.lo <= cur_q.hi) begin
               if (tuple_in.hi > cur_q.hi) cur_q.hi <= tuple_in.hi;
            end else begin
               // Disjoint (including merely adjacent) ranges close the open one.
               total_q <= total_q + span;
               cur_q   <= tuple_in;
            end
         end
      end
   end

endmodule

// File: rtl/aoc5_range_drain.sv
// Drains the sorted tuple banks two tuples per address, feeding each tuple to
// the range accumulator, and reports the total covered-ID count.
module aoc5_range_drain
   import aoc5_pkg::*;
#(
   parameter int TOTAL_WIDTH = 64
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        en_in,
   input  logic                        start_in,
   input  logic [`BANK_ADDR_WIDTH:0]   count_in,
   input  tuple_pair_t                 even_data_in,
   input  tuple_pair_t                 odd_data_in,
   output logic [`BANK_ADDR_WIDTH-1:0] read_addr_out,
   output logic                        read_en_out,
   output logic [TOTAL_WIDTH-1:0]      total_out,
   output logic                        busy_out,
   output logic                        done_out
);

   localparam int AW = `BANK_ADDR_WIDTH;

   // Bank read protocol: a read_en_out pulse in cycle t presents the tuples
   // at read_addr_out / +1 in cycle t+1; the bank holds them until the next
   // pulse, so stalls never lose data.
   drain_state_t  state_q, state_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW:0]   count_q, count_d;
   tuple_pair_t   odd_q, odd_d;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          acc_clear, acc_valid, acc_flush;
   tuple_pair_t   acc_tuple;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         count_q <= '0;
         odd_q   <= '0;
      end else if (en_in) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         odd_q   <= odd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      count_d   = count_q;
      odd_d     = odd_q;
      rd_en     = 1'b0;
      rd_addr   = '0;
      acc_clear = 1'b0;
      acc_valid = 1'b0;
      acc_flush = 1'b0;
      acc_tuple = even_data_in;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_in) begin
               acc_clear = 1'b1;
               idx_d     = '0;
               count_d   = count_in;
               state_d   = (count_in != '0) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            rd_en   = 1'b1;
            rd_addr = idx_q[AW-1:0];
            state_d = S_PROC_EVEN;
         end
         S_PROC_EVEN: begin
            acc_valid = 1'b1;
            odd_d     = odd_data_in;
            if ((idx_q + (AW+1)'(1) == count_q) || is_sentinel(even_data_in))
               state_d = S_FLUSH;
            else
               state_d = S_PROC_ODD;
         end
         S_PROC_ODD: begin
            acc_valid = 1'b1;
            acc_tuple = odd_q;
            idx_d     = idx_q + (AW+1)'(2);
            if ((idx_q + (AW+1)'(2) == count_q) || is_sentinel(odd_q)) begin
               state_d = S_FLUSH;
            end else begin
               rd_en   = 1'b1;
               rd_addr = idx_q[AW-1:0] + AW'(2);
               state_d = S_PROC_EVEN;
            end
         end
         S_FLUSH: begin
            acc_flush = 1'b1;
            state_d   = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign read_en_out   = rd_en & en_in;
   assign read_addr_out = en_in ? rd_addr : '0;
   assign busy_out      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_out      = (state_q == S_DONE);

   aoc5_range_accum #(.TOTAL_WIDTH(TOTAL_WIDTH)) u_accum (
      .clock       (clock),
      .reset       (reset),
      .en          (en_in),
      .clear       (acc_clear),
      .tuple_valid (acc_valid),
      .tuple_in    (acc_tuple),
      .flush       (acc_flush),
      .total       (total_out)
   );

endmodule

// File: tb/tb_aoc5_range_drain.sv
// Bench for aoc5_range_drain: bank memory model, coverage-bitmap reference,
// scoreboard queues for totals and read addresses/cycles.
module tb_aoc5_range_drain;
   import aoc5_pkg::*;

   localparam int AW = `BANK_ADDR_WIDTH;
   localparam int TW = 64;

   logic              clock = 1'b0;
   logic              reset;
   logic              en_in;
   logic              start_in;
   logic [AW:0]       count_in;
   tuple_pair_t       even_data_in, odd_data_in;
   logic [AW-1:0]     read_addr_out;
   logic              read_en_out;
   logic [TW-1:0]     total_out;
   logic              busy_out;
   logic              done_out;

   tuple_pair_t       mem [0:(1<<AW)-1];

   logic [TW-1:0]     exp_q[$];
   logic [AW-1:0]     rd_addr_q[$];
   int                rd_cyc_q[$];

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clock = ~clock;

   aoc5_range_drain #(.TOTAL_WIDTH(TW)) dut (
      .clock         (clock),
      .reset         (reset),
      .en_in         (en_in),
      .start_in      (start_in),
      .count_in      (count_in),
      .even_data_in  (even_data_in),
      .odd_data_in   (odd_data_in),
      .read_addr_out (read_addr_out),
      .read_en_out   (read_en_out),
      .total_out     (total_out),
      .busy_out      (busy_out),
      .done_out      (done_out)
   );

   // Bank model: data appears the cycle after a read and is held.
   always @(posedge clock) begin
      if (read_en_out) begin
         even_data_in <= mem[read_addr_out];
         odd_data_in  <= mem[read_addr_out + AW'(1)];
      end
   end

   task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < (1<<AW); i++) begin
         mem[i].lo = 32'd600;
         mem[i].hi = 32'd900;
      end
   endtask

   task automatic set_t(input int i, input int lo, input int hi);
      mem[i].lo = lo;
      mem[i].hi = hi;
   endtask

   // Reference: covered IDs by bitmap; read schedule and done cycle from the
   // number of tuple visits (count-limited, sentinel visited then flushed).
   task automatic push_expect(input int cnt, input int stall_at, output int exp_n);
      logic [1023:0] cov;
      logic [TW-1:0] tot;
      int s, l, c;
      cov = '0;
      s = cnt;
      for (int i = cnt - 1; i >= 0; i--)
         if (mem[i] == TUPLE_SENTINEL) s = i;
      for (int i = 0; i < s; i++)
         for (int id = int'(mem[i].lo); id <= int'(mem[i].hi); id++) cov[id] = 1'b1;
      tot = '0;
      for (int id = 0; id < 1024; id++) tot += TW'(cov[id]);
      exp_q.push_back(tot);
      l = (s < cnt) ? s + 1 : cnt;
      for (int j = 0; 2 * j < l; j++) begin
         c = 1 + 2 * j;
         if (stall_at > 0 && c >= stall_at) c += 3;
         rd_addr_q.push_back(AW'(2 * j));
         rd_cyc_q.push_back(c);
      end
      if (cnt == 0) exp_n = 1;
      else begin
         exp_n = 3 + l;
         if (stall_at > 0 && exp_n >= stall_at) exp_n += 3;
      end
   endtask

   task automatic run_drain(input string name, input int cnt, input int stall_at);
      int exp_n, n, a_cyc;
      logic [AW-1:0] a_exp;
      push_expect(cnt, stall_at, exp_n);
      @(negedge clock);
      count_in = cnt[AW:0];
      start_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;
      count_in = '0;
      n = 1;
      check_val({name, ".busy"}, TW'(busy_out), TW'(cnt != 0));
      forever begin
         if (stall_at > 0 && n == stall_at) en_in = 1'b0;
         if (stall_at > 0 && n == stall_at + 3) en_in = 1'b1;
         #1;
         if (read_en_out) begin
            if (rd_addr_q.size() == 0) begin
               check_val({name, ".extra_read_addr"}, TW'(read_addr_out), TW'(-1));
            end else begin
               a_exp = rd_addr_q.pop_front();
               a_cyc = rd_cyc_q.pop_front();
               check_val({name, ".read_addr"}, TW'(read_addr_out), TW'(a_exp));
               check_val({name, ".read_cycle"}, TW'(n), TW'(a_cyc));
            end
         end
         if (done_out) break;
         if (n >= 200) begin
            check_val({name, ".done_timeout"}, TW'(done_out), TW'(1));
            break;
         end
         @(negedge clock);
         n++;
      end
      en_in = 1'b1;
      check_val({name, ".done_cycle"}, TW'(n), TW'(exp_n));
      check_val({name, ".total"}, total_out, exp_q.pop_front());
      check_val({name, ".reads_left"}, TW'(rd_addr_q.size()), TW'(0));
      rd_addr_q.delete();
      rd_cyc_q.delete();
      @(negedge clock);
      check_val({name, ".done_hold"}, TW'(done_out), TW'(1));
      check_val({name, ".busy_idle"}, TW'(busy_out), TW'(0));
   endtask

   task automatic load_scen1();
      clear_mem();
      set_t(0, 3, 5);
      set_t(1, 10, 14);
      set_t(2, 12, 18);
      set_t(3, 16, 20);
   endtask

   initial begin
      int cnt, lo;
      reset    = 1'b1;
      en_in    = 1'b1;
      start_in = 1'b0;
      count_in = '0;
      clear_mem();
      repeat (2) @(negedge clock);
      check_val("rst.read_en", TW'(read_en_out), 0);
      check_val("rst.read_addr", TW'(read_addr_out), 0);
      check_val("rst.total", total_out, 0);
      check_val("rst.busy", TW'(busy_out), 0);
      check_val("rst.done", TW'(done_out), 0);
      reset = 1'b0;

      load_scen1();
      run_drain("scen1", 4, 0);

      clear_mem();
      set_t(0, 1, 1);
      set_t(1, 2, 2);
      mem[2] = TUPLE_SENTINEL;
      run_drain("sentinel", 8, 0);

      run_drain("count0", 0, 0);

      clear_mem();
      set_t(0, 1, 100);
      set_t(1, 5, 10);
      set_t(2, 20, 30);
      run_drain("contained", 3, 0);

      load_scen1();
      run_drain("stall", 4, 3);

      // Reset mid-drain, then restart.
      load_scen1();
      @(negedge clock);
      count_in = 4;
      start_in = 1'b1;
      @(negedge clock);
      start_in = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_val("midrst.read_en", TW'(read_en_out), 0);
      check_val("midrst.read_addr", TW'(read_addr_out), 0);
      check_val("midrst.total", total_out, 0);
      check_val("midrst.busy", TW'(busy_out), 0);
      check_val("midrst.done", TW'(done_out), 0);
      reset = 1'b0;
      @(negedge clock);
      check_val("midrst.idle_done", TW'(done_out), 0);
      clear_mem();
      set_t(0, 7, 9);
      set_t(1, 8, 8);
      run_drain("restart", 2, 0);

      for (int r = 0; r < 4; r++) begin
         clear_mem();
         cnt = $urandom_range(1, 12);
         lo = 0;
         for (int i = 0; i < cnt; i++) begin
            lo += $urandom_range(0, 8);
            set_t(i, lo, lo + $urandom_range(0, 15));
         end
         if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, cnt - 1)] = TUPLE_SENTINEL;
         run_drain("random", cnt, 0);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/aoc5_range_drain.md
# aoc5_range_drain

Sequential reader that drains the fully sorted tuple banks after the last merge phase, coalescing overlapping inclusive ranges and accumulating the total count of covered IDs. It drives the same banked read path as the merge phase (even/odd banks, two tuples per address) and sits between the sort engine and the result register.

## Interface
Parameters:
- TOTAL_WIDTH, 64: width of the accumulated total.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- en_in  in  1  global enable; low freezes all state.
- start_in  in  1  begin drain; honoured only in IDLE or DONE.
- count_in  in  `BANK_ADDR_WIDTH+1  number of valid tuples; sampled on start.
- even_data_in  in  tuple_pair_t  tuple at read address (even index).
- odd_data_in  in  tuple_pair_t  tuple at read address + 1.
- read_addr_out  out  `BANK_ADDR_WIDTH  tuple index, always even.
- read_en_out  out  1  read strobe.
- total_out  out  TOTAL_WIDTH  accumulated covered-ID count.
- busy_out  out  1  high in any state except IDLE/DONE.
- done_out  out  1  high in DONE.

## Operation
- tuple_pair_t = {lo, hi}, inclusive, lo <= hi guaranteed upstream; sorted ascending by lo. All-ones tuple = padding sentinel.
- Bank read: data for read_en_out at cycle t is valid at cycle t+1 and held until the next read_en_out.
- States: IDLE, READ, PROC_EVEN, PROC_ODD, FLUSH, DONE.
- IDLE/DONE + start_in: latch count_in, clear total, idx=0, have_cur=0; go READ if count>0, else DONE (total 0, no reads).
- READ: read_en_out=1, read_addr_out=idx → PROC_EVEN.
- PROC_EVEN: process even_data_in; latch odd_data_in into odd_q. If idx+1==count or even tuple is sentinel → FLUSH, else → PROC_ODD.
- PROC_ODD: process odd_q; idx+=2. If idx+2==count or odd_q is sentinel → FLUSH; else read_en_out=1, read_addr_out=idx+2 → PROC_EVEN.
- Process tuple t (ignored if sentinel): if !have_cur: cur=t, have_cur=1. Else if t.lo <= cur.hi: cur.hi = max(cur.hi, t.hi). Else total += cur.hi-cur.lo+1; cur=t.
- FLUSH: if have_cur, total += cur.hi-cur.lo+1 → DONE.
- Arithmetic: span computed in TOTAL_WIDTH, total wraps modulo 2^TOTAL_WIDTH. Adjacent (non-overlapping) ranges are not merged; count is identical.
- start_in while busy: ignored.

## Timing
- Reset values: read_en_out 0, read_addr_out 0, total_out 0, busy_out 0, done_out 0; state IDLE.
- read_en_out/read_addr_out combinational from state, gated by en_in; all other outputs registered.
- start sampled at edge k: READ in cycle k+1, first PROC_EVEN k+2; steady state 2 cycles per address.
- Even count N: last PROC_ODD cycle k+1+N, FLUSH k+2+N, done_out high from k+3+N. Odd N: FLUSH k+2+N, done k+3+N.
- en_in low: no transitions, read_en_out 0, registers hold; bank data hold guarantees correctness on resume.
- Reset mid-drain: immediate return to IDLE with reset values; no partial total retained.
- done_out stays high until next accepted start.

## Structure
- Shared package aoc5_pkg: tuple_pair_t, `BANK_ADDR_WIDTH, sentinel constant TUPLE_SENTINEL (all ones).
- One sub-module natural: aoc5_range_accum (cur register, have_cur, merge/accumulate datapath; one tuple per enabled cycle, flush strobe).

## Test plan
- count=4, tuples (3,5),(10,14),(12,18),(16,20), start at k → reads at addr 0 (k+1), 2 (k+3); total_out=14; done_out at k+7.
- count=8, tuples (1,1),(2,2), sentinel at index 2 → no read at addr 4; total_out=2.
- count=0 → no read_en_out ever; done_out next cycle, total_out=0.
- count=3, (1,100),(5,10),(20,30) → contained ranges, total_out=100; reads only addr 0 and 2.
- Scenario 1 with en_in low 3 cycles during first PROC_ODD → read_en_out 0 during stall, total_out=14, done_out at k+10.
- Reset asserted mid-scenario 1, then restart with count=2, (7,9),(8,8) → all outputs zero after reset; total_out=3.
